// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall bubble/hold, exception flush and MADD accumulator return path.
// Define EX_MEM_ACC_EN to keep the hilo_temp/cnt registers; otherwise they are tied to zero.
module ex_mem (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stop_all,
  input  logic        flush_input,
  input  logic [4:0]  ex_write_reg_address_input,
  input  logic        ex_write_reg_enable_input,
  input  logic [31:0] ex_write_data_input,
  input  logic [31:0] ex_hi_input,
  input  logic [31:0] ex_lo_input,
  input  logic        ex_write_hilo_enable_input,
  input  logic [7:0]  ex_aluop_input,
  input  logic [31:0] ex_mem_address_input,
  input  logic [31:0] ex_reg2_input,
  input  logic        ex_cp0_write_enable_input,
  input  logic [4:0]  ex_cp0_write_address_input,
  input  logic [31:0] ex_cp0_write_data_input,
  input  logic [31:0] ex_exception_type_input,
  input  logic        ex_is_in_delay_slot_input,
  input  logic [31:0] ex_current_instruction_address,
  input  logic [63:0] hilo_temp_input,
  input  logic [1:0]  cnt_input,
  output logic [4:0]  mem_write_reg_address_output,
  output logic        mem_write_reg_enable_output,
  output logic [31:0] mem_write_data_output,
  output logic [31:0] mem_hi_output,
  output logic [31:0] mem_lo_output,
  output logic        mem_write_hilo_enable_output,
  output logic [7:0]  mem_aluop_output,
  output logic [31:0] mem_mem_address_output,
  output logic [31:0] mem_reg2_output,
  output logic        mem_cp0_write_enable_output,
  output logic [4:0]  mem_cp0_write_address_output,
  output logic [31:0] mem_cp0_write_data_output,
  output logic [31:0] mem_exception_type_output,
  output logic        mem_is_in_delay_slot_output,
  output logic [31:0] mem_current_instruction_address,
  output logic [63:0] hilo_temp_output,
  output logic [1:0]  cnt_output
);

  typedef struct packed {
    logic [4:0]  wreg_addr;
    logic        wreg_en;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo_en;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [31:0] exc_type;
    logic        in_dslot;
    logic [31:0] pc;
  } stage_t;

  stage_t ex_s, stage_d, stage_q;
  logic   ex_stall, mem_stall;

  assign ex_stall  = stop_all[3];
  assign mem_stall = stop_all[4];

  assign ex_s = '{
    wreg_addr: ex_write_reg_address_input,
    wreg_en:   ex_write_reg_enable_input,
    wdata:     ex_write_data_input,
    hi:        ex_hi_input,
    lo:        ex_lo_input,
    whilo_en:  ex_write_hilo_enable_input,
    aluop:     ex_aluop_input,
    mem_addr:  ex_mem_address_input,
    reg2:      ex_reg2_input,
    cp0_we:    ex_cp0_write_enable_input,
    cp0_waddr: ex_cp0_write_address_input,
    cp0_wdata: ex_cp0_write_data_input,
    exc_type:  ex_exception_type_input,
    in_dslot:  ex_is_in_delay_slot_input,
    pc:        ex_current_instruction_address
  };

  // All-zero payload is the NOP: aluop 0, addresses 0, enables off.
  always_comb begin
    stage_d = stage_q;
    if (flush_input)     stage_d = '0;
    else if (!ex_stall)  stage_d = ex_s;
    else if (!mem_stall) stage_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign mem_write_reg_address_output    = stage_q.wreg_addr;
  assign mem_write_reg_enable_output     = stage_q.wreg_en;
  assign mem_write_data_output           = stage_q.wdata;
  assign mem_hi_output                   = stage_q.hi;
  assign mem_lo_output                   = stage_q.lo;
  assign mem_write_hilo_enable_output    = stage_q.whilo_en;
  assign mem_aluop_output                = stage_q.aluop;
  assign mem_mem_address_output          = stage_q.mem_addr;
  assign mem_reg2_output                 = stage_q.reg2;
  assign mem_cp0_write_enable_output     = stage_q.cp0_we;
  assign mem_cp0_write_address_output    = stage_q.cp0_waddr;
  assign mem_cp0_write_data_output       = stage_q.cp0_wdata;
  assign mem_exception_type_output       = stage_q.exc_type;
  assign mem_is_in_delay_slot_output     = stage_q.in_dslot;
  assign mem_current_instruction_address = stage_q.pc;

`ifdef EX_MEM_ACC_EN
  logic [63:0] hilo_temp_d, hilo_temp_q;
  logic [1:0]  cnt_d, cnt_q;

  // While EX is stalled (bubble or hold) the partial product circulates back to EX.
  always_comb begin
    hilo_temp_d = '0;
    cnt_d       = '0;
    if (!flush_input && ex_stall) begin
      hilo_temp_d = hilo_temp_input;
      cnt_d       = cnt_input;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hilo_temp_q <= '0;
      cnt_q       <= '0;
    end else begin
      hilo_temp_q <= hilo_temp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hilo_temp_output = hilo_temp_q;
  assign cnt_output       = cnt_q;
  logic unused_stall;
  assign unused_stall = ^{stop_all[5], stop_all[2:0]};
`else
  assign hilo_temp_output = 64'h0;
  assign cnt_output       = 2'b00;
  logic unused_acc;
  assign unused_acc = ^{hilo_temp_input, cnt_input, stop_all[5], stop_all[2:0]};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: per-cycle reference model plus directed literal checks.
module tb_ex_mem;
  localparam int MW = 278;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stop_all;
  logic        flush_input;
  logic [4:0]  ex_write_reg_address_input;
  logic        ex_write_reg_enable_input;
  logic [31:0] ex_write_data_input, ex_hi_input, ex_lo_input;
  logic        ex_write_hilo_enable_input;
  logic [7:0]  ex_aluop_input;
  logic [31:0] ex_mem_address_input, ex_reg2_input;
  logic        ex_cp0_write_enable_input;
  logic [4:0]  ex_cp0_write_address_input;
  logic [31:0] ex_cp0_write_data_input, ex_exception_type_input;
  logic        ex_is_in_delay_slot_input;
  logic [31:0] ex_current_instruction_address;
  logic [63:0] hilo_temp_input;
  logic [1:0]  cnt_input;
  logic [4:0]  mem_write_reg_address_output;
  logic        mem_write_reg_enable_output;
  logic [31:0] mem_write_data_output, mem_hi_output, mem_lo_output;
  logic        mem_write_hilo_enable_output;
  logic [7:0]  mem_aluop_output;
  logic [31:0] mem_mem_address_output, mem_reg2_output;
  logic        mem_cp0_write_enable_output;
  logic [4:0]  mem_cp0_write_address_output;
  logic [31:0] mem_cp0_write_data_output, mem_exception_type_output;
  logic        mem_is_in_delay_slot_output;
  logic [31:0] mem_current_instruction_address;
  logic [63:0] hilo_temp_output;
  logic [1:0]  cnt_output;

  ex_mem dut (
    .clock(clock), .reset(reset), .stop_all(stop_all), .flush_input(flush_input),
    .ex_write_reg_address_input(ex_write_reg_address_input),
    .ex_write_reg_enable_input(ex_write_reg_enable_input),
    .ex_write_data_input(ex_write_data_input),
    .ex_hi_input(ex_hi_input), .ex_lo_input(ex_lo_input),
    .ex_write_hilo_enable_input(ex_write_hilo_enable_input),
    .ex_aluop_input(ex_aluop_input),
    .ex_mem_address_input(ex_mem_address_input), .ex_reg2_input(ex_reg2_input),
    .ex_cp0_write_enable_input(ex_cp0_write_enable_input),
    .ex_cp0_write_address_input(ex_cp0_write_address_input),
    .ex_cp0_write_data_input(ex_cp0_write_data_input),
    .ex_exception_type_input(ex_exception_type_input),
    .ex_is_in_delay_slot_input(ex_is_in_delay_slot_input),
    .ex_current_instruction_address(ex_current_instruction_address),
    .hilo_temp_input(hilo_temp_input), .cnt_input(cnt_input),
    .mem_write_reg_address_output(mem_write_reg_address_output),
    .mem_write_reg_enable_output(mem_write_reg_enable_output),
    .mem_write_data_output(mem_write_data_output),
    .mem_hi_output(mem_hi_output), .mem_lo_output(mem_lo_output),
    .mem_write_hilo_enable_output(mem_write_hilo_enable_output),
    .mem_aluop_output(mem_aluop_output),
    .mem_mem_address_output(mem_mem_address_output), .mem_reg2_output(mem_reg2_output),
    .mem_cp0_write_enable_output(mem_cp0_write_enable_output),
    .mem_cp0_write_address_output(mem_cp0_write_address_output),
    .mem_cp0_write_data_output(mem_cp0_write_data_output),
    .mem_exception_type_output(mem_exception_type_output),
    .mem_is_in_delay_slot_output(mem_is_in_delay_slot_output),
    .mem_current_instruction_address(mem_current_instruction_address),
    .hilo_temp_output(hilo_temp_output), .cnt_output(cnt_output)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %0s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: what MEM should hold after each edge, from the stage rules.
  logic [MW-1:0] in_vec, dut_vec, exp_mem;
  logic [63:0]   exp_hilo;
  logic [1:0]    exp_cnt;
  bit            model_ok = 0;

  assign in_vec = {ex_write_reg_address_input, ex_write_reg_enable_input, ex_write_data_input,
                   ex_hi_input, ex_lo_input, ex_write_hilo_enable_input, ex_aluop_input,
                   ex_mem_address_input, ex_reg2_input, ex_cp0_write_enable_input,
                   ex_cp0_write_address_input, ex_cp0_write_data_input, ex_exception_type_input,
                   ex_is_in_delay_slot_input, ex_current_instruction_address};
  assign dut_vec = {mem_write_reg_address_output, mem_write_reg_enable_output, mem_write_data_output,
                    mem_hi_output, mem_lo_output, mem_write_hilo_enable_output, mem_aluop_output,
                    mem_mem_address_output, mem_reg2_output, mem_cp0_write_enable_output,
                    mem_cp0_write_address_output, mem_cp0_write_data_output, mem_exception_type_output,
                    mem_is_in_delay_slot_output, mem_current_instruction_address};

  always @(posedge clock) begin
    bit kill, ex_st, mem_st;
    kill   = reset || flush_input;
    ex_st  = stop_all[3];
    mem_st = stop_all[4];
    if (reset) model_ok = 1;
    if (kill)                 exp_mem = '0;
    else if (!ex_st)          exp_mem = in_vec;
    else if (!mem_st)         exp_mem = '0;
`ifdef EX_MEM_ACC_EN
    if (!kill && ex_st) begin exp_hilo = hilo_temp_input; exp_cnt = cnt_input; end
    else begin exp_hilo = 64'h0; exp_cnt = 2'b00; end
`else
    exp_hilo = 64'h0; exp_cnt = 2'b00;
`endif
  end

  always @(negedge clock) begin
    if (model_ok) begin
      chk("model_mem_stage", dut_vec, exp_mem);
      chk("model_acc", {hilo_temp_output, cnt_output}, {exp_hilo, exp_cnt});
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic fill_random();
    ex_write_reg_address_input = 5'($urandom_range(1, 31));
    ex_write_reg_enable_input = 1'b1;
    ex_write_data_input = $urandom | 32'h1;
    ex_hi_input = $urandom; ex_lo_input = $urandom;
    ex_write_hilo_enable_input = 1'b1;
    ex_aluop_input = 8'($urandom_range(1, 255));
    ex_mem_address_input = $urandom; ex_reg2_input = $urandom;
    ex_cp0_write_enable_input = 1'b1;
    ex_cp0_write_address_input = 5'($urandom_range(1, 31));
    ex_cp0_write_data_input = $urandom; ex_exception_type_input = $urandom;
    ex_is_in_delay_slot_input = 1'b1;
    ex_current_instruction_address = $urandom;
    hilo_temp_input = {$urandom, $urandom};
    cnt_input = 2'($urandom_range(1, 3));
  endtask

`ifdef EX_MEM_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  initial begin
    bit acc_on;
    acc_on = ACC;
    reset = 1; flush_input = 1; stop_all = 6'h3f;
    fill_random();
    cyc();
    chk("reset_wdata", mem_write_data_output, 0);
    chk("reset_aluop", mem_aluop_output, 8'h00);
    chk("reset_wen", mem_write_reg_enable_output, 0);
    chk("reset_cnt", cnt_output, 0);

    reset = 0; flush_input = 0; stop_all = 0;
    fill_random();
    ex_write_data_input = 32'hDEADBEEF; ex_write_reg_address_input = 5'd8; ex_write_reg_enable_input = 1;
    cyc();
    chk("adv_wdata", mem_write_data_output, 32'hDEADBEEF);
    chk("adv_waddr", mem_write_reg_address_output, 5'd8);
    chk("adv_wen", mem_write_reg_enable_output, 1);
    chk("adv_cnt", cnt_output, 0);

    fill_random();
    stop_all = 6'b001000; cnt_input = 2'd1; hilo_temp_input = 64'h1_0000_0002;
    cyc();
    chk("bub_wen", mem_write_reg_enable_output, 0);
    chk("bub_aluop", mem_aluop_output, 0);
    chk("bub_cnt", cnt_output, acc_on ? 2'd1 : 2'd0);
    chk("bub_hilo", hilo_temp_output, acc_on ? 64'h1_0000_0002 : 64'h0);
    stop_all = 0; fill_random();
    cyc();
    chk("bub_release_cnt", cnt_output, 0);
    chk("bub_release_hilo", hilo_temp_output, 0);

    fill_random(); ex_write_data_input = 32'h12345678;
    cyc();
    stop_all = 6'b011000;
    for (int i = 0; i < 3; i++) begin
      fill_random(); cnt_input = 2'd3;
      cyc();
      chk("hold_wdata", mem_write_data_output, 32'h12345678);
      chk("hold_cnt", cnt_output, acc_on ? 2'd3 : 2'd0);
    end

    fill_random(); flush_input = 1; cnt_input = 2'd1;
    cyc();
    chk("flush_wdata", mem_write_data_output, 0);
    chk("flush_pc", mem_current_instruction_address, 0);
    chk("flush_cnt", cnt_output, 0);
    flush_input = 0;

    // Full MADD handshake followed by a clean advance.
    stop_all = 6'b001000; fill_random(); cnt_input = 2'd1;
    cyc();
    stop_all = 0; fill_random(); ex_write_data_input = 32'hA5A5_0001;
    cyc();
    chk("madd_done_wdata", mem_write_data_output, 32'hA5A5_0001);
    chk("madd_done_cnt", cnt_output, 0);

    // Stall and flush interleavings driven through the model.
    for (int i = 0; i < 40; i++) begin
      fill_random();
      stop_all = 6'($urandom) & 6'b011000 | 6'($urandom) & 6'b100111;
      flush_input = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 15) == 0);
      cyc();
    end
    reset = 0; flush_input = 0; stop_all = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the EX stage and the MEM stage of the five-stage MIPS core. Captures the EX result, HI/LO write, memory-access operands, CP0 write and exception context each cycle, and presents them to MEM. Applies the global stall vector (bubble or hold) and the exception flush. Also carries the two-cycle MADD/MADDU/MSUB/MSUBU accumulator state (`hilo_temp`, `cnt`) back to EX across stall cycles.

## Interface
Parameters: none; widths come from `defines.v`.

- `clock` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high (`ResetEnable`).
- `stop_all` in 6: stall vector; bit 3 = EX stall, bit 4 = MEM stall.
- `flush_input` in 1: exception flush.
- `ex_write_reg_address_input` in 5 / `ex_write_reg_enable_input` in 1 / `ex_write_data_input` in 32: GPR writeback.
- `ex_hi_input`, `ex_lo_input` in 32 / `ex_write_hilo_enable_input` in 1: HI/LO writeback.
- `ex_aluop_input` in 8: ALU op, used by MEM for load/store decode.
- `ex_mem_address_input` in 32 / `ex_reg2_input` in 32: effective address, store data.
- `ex_cp0_write_enable_input` in 1 / `ex_cp0_write_address_input` in 5 / `ex_cp0_write_data_input` in 32.
- `ex_exception_type_input` in 32 / `ex_is_in_delay_slot_input` in 1 / `ex_current_instruction_address` in 32.
- `hilo_temp_input` in 64 / `cnt_input` in 2: accumulator state from EX.
- `mem_*_output` out: one registered output per EX input above (same names, `ex_` → `mem_`, `_input` → `_output`; `mem_current_instruction_address` for the PC).
- `hilo_temp_output` out 64 / `cnt_output` out 2: accumulator state back to EX.

## Operation
Priority per posedge, highest first:
- **Reset** (`reset==1`): all outputs to 0. `mem_aluop_output` = `EXE_NOP_OP` (8'h00). Address outputs = `NOPRegisterAddress` (0). Enables = `WriteDisable`. `cnt_output`=0, `hilo_temp_output`=0.
- **Flush** (`flush_input==1`): same values as reset, including the accumulator state.
- **Bubble** (`stop_all[3]==Stop && stop_all[4]==NoStop`):
  - all `mem_*` outputs take the reset values (NOP into MEM);
  - `hilo_temp_output`<=`hilo_temp_input`, `cnt_output`<=`cnt_input`.
- **Advance** (`stop_all[3]==NoStop`):
  - every `mem_*` output <= its corresponding input;
  - `hilo_temp_output`<=0, `cnt_output`<=0.
- **Hold** (`stop_all[3]==Stop && stop_all[4]==Stop`):
  - `mem_*` outputs keep their values;
  - `hilo_temp_output`<=`hilo_temp_input`, `cnt_output`<=`cnt_input`.
- Accumulator handshake with EX:
  - cycle 1: EX asserts the EX stall and drives product with `cnt_input`=1; bubble captures it;
  - cycle 2: EX sees `cnt_output`=1, completes, releases the stall; advance clears `cnt_output`.
- `cnt_input` value 2'b11 is never produced by EX; the block registers it unchanged.

## Timing
- Latency: 1 cycle input→output on advance; no combinational paths from inputs to outputs.
- Flush overrides any stall in the same cycle; reset overrides flush.
- Reset or flush mid-MADD: `cnt_output`=0 next cycle, so the accumulation restarts from zero.
- Stall deasserted in the same cycle an instruction arrives: that instruction is captured (advance).
- Outputs hold indefinitely under continuous hold; no timeout.

## Configuration
- `EX_MEM_ACC_EN` defined:
  - `hilo_temp`/`cnt` registers present;
  - behaviour as above.
- Undefined:
  - registers removed;
  - `hilo_temp_output` tied to 64'h0 and `cnt_output` tied to 2'b00;
  - `hilo_temp_input` and `cnt_input` ignored;
  - all `mem_*` behaviour unchanged.

## Test plan
- **Reset:** assert reset with all inputs non-zero → next cycle all outputs 0, aluop 8'h00, `cnt_output`=0.
- **Advance:** `ex_write_data_input`=32'hDEADBEEF, addr 5'd8, enable 1, `stop_all`=0 → next cycle `mem_write_data_output`=32'hDEADBEEF, addr 8, enable 1, `cnt_output`=0.
- **Bubble:**
  - stimulus: `stop_all`=6'b001000, `cnt_input`=1, `hilo_temp_input`=64'h1_0000_0002;
  - response: `mem_write_reg_enable_output`=0, `cnt_output`=1, `hilo_temp_output`=64'h1_0000_0002;
  - then `stop_all`=0 → `cnt_output`=0.
- **Hold:**
  - stimulus: after advancing data 32'h12345678, drive `stop_all`=6'b011000 for 3 cycles with changing inputs;
  - response: `mem_write_data_output` stays 32'h12345678.
- **Flush over stall:**
  - stimulus: `flush_input`=1 with `stop_all`=6'b011000 and `cnt_input`=1;
  - response: all outputs 0, `cnt_output`=0.
- **Macro off:** build without `EX_MEM_ACC_EN`, run the bubble case → `cnt_output`=0 and `hilo_temp_output`=0 throughout; `mem_*` outputs identical to the macro-on run.
